mem_stage: RTL

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the ALU/MEM pipeline register and upstream of MEM/WB. Non-memory instructions pass through with one registered cycle. Loads and stores are issued to the data RAM through a request/ready handshake, and the upstream pipeline is stalled until the access completes. The stage also handles byte/halfword store alignment, load extraction and sign extension, and misaligned or illegal access detection.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_align.sv | 69 ++++++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage: widths, funct3
// encodings, FSM states and byte-enable patterns.
package mem_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/ready bus between the memory stage (master) and the RAM (slave).
interface mem_stage_if import mem_pkg::*; ();

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_align.sv
// Combinational datapath helpers: store lane replication and byte enables,
// fault detection for the incoming instruction, and load extraction/extension.
module mem_align import mem_pkg::*; (
  input  logic            load_in,
  input  logic            store_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      off_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            fault,
  output logic [XLEN-1:0] store_wdata,
  output logic [3:0]      store_be,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data
);

  logic        illegal_f3;
  logic        misaligned;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    illegal_f3 = 1'b0;
    if (load_in) begin
      illegal_f3 = (funct3_in == 3'd3) || (funct3_in == 3'd6) || (funct3_in == 3'd7);
    end else if (store_in) begin
      illegal_f3 = (funct3_in > F3_SW);
    end
    misaligned = ((funct3_in[1:0] == 2'b01) && off_in[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (off_in != 2'b00));
    fault = (load_in && store_in) ||
            ((load_in || store_in) && (illegal_f3 || misaligned));
  end

  always_comb begin
    store_wdata = rs2_in;
    store_be    = BE_WORD;
    case (funct3_in[1:0])
      2'b00: begin
        store_wdata = {4{rs2_in[7:0]}};
        store_be    = BE_BYTE << off_in;
      end
      2'b01: begin
        store_wdata = {2{rs2_in[15:0]}};
        store_be    = BE_HALF << off_in;
      end
      default: begin
        store_wdata = rs2_in;
        store_be    = BE_WORD;
      end
    endcase
  end

  // Byte lane chosen by the low address bits; halfwords use only bit 1.
  always_comb begin
    byte_v    = rdata[{ld_off, 3'b000} +: 8];
    half_v    = rdata[{ld_off[1], 4'b0000} +: 16];
    load_data = rdata;
    case (ld_funct3)
      F3_LB:   load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   load_data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and
// runs loads/stores through the RAM handshake while stalling upstream.
module mem_stage import mem_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [XLEN-1:0]       addr_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic [2:0]            funct3_in,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] wb_addr_in,
  output logic                  stall_out,
  mem_stage_if.master           bus,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  exc_out
);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       req_addr_q, req_addr_d;
  logic [2:0]            req_funct3_q, req_funct3_d;
  logic [REG_ADDR_W-1:0] req_rd_q, req_rd_d;
  logic                  req_reg_write_q, req_reg_write_d;
  logic [3:0]            req_be_q, req_be_d;
  logic [XLEN-1:0]       req_wdata_q, req_wdata_d;
  logic                  req_we_q, req_we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic                  exc_q, exc_d;

  logic                  fault;
  logic                  mem_op;
  logic [XLEN-1:0]       store_wdata;
  logic [3:0]            store_be;
  logic [XLEN-1:0]       load_data;

  mem_align u_align (
    .load_in     (load_in),
    .store_in    (store_in),
    .funct3_in   (funct3_in),
    .off_in      (addr_in[1:0]),
    .rs2_in      (rs2_data_in),
    .fault       (fault),
    .store_wdata (store_wdata),
    .store_be    (store_be),
    .ld_funct3   (req_funct3_q),
    .ld_off      (req_addr_q[1:0]),
    .rdata       (bus.mem_rdata),
    .load_data   (load_data)
  );

  assign mem_op = load_in || store_in;

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    req_funct3_d    = req_funct3_q;
    req_rd_d        = req_rd_q;
    req_reg_write_d = req_reg_write_q;
    req_be_d        = req_be_q;
    req_wdata_d     = req_wdata_q;
    req_we_d        = req_we_q;
    wb_valid_d      = wb_valid_q;
    wb_data_d       = wb_data_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_addr_d       = wb_addr_q;
    exc_d           = exc_q;
    stall_out       = 1'b0;

    case (state_q)
      IDLE: begin
        stall_out = valid_in && mem_op && !fault;
        if (!valid_in) begin
          wb_valid_d = 1'b0;
          exc_d      = 1'b0;
        end else if (!mem_op) begin
          wb_valid_d     = 1'b1;
          wb_data_d      = addr_in;
          wb_reg_write_d = reg_write_in;
          wb_addr_d      = wb_addr_in;
          exc_d          = 1'b0;
        end else if (fault) begin
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_addr_d      = wb_addr_in;
          exc_d          = 1'b1;
        end else begin
          // Loads leave write data and enables at zero so the RAM never sees stale lanes.
          req_addr_d      = addr_in;
          req_funct3_d    = funct3_in;
          req_rd_d        = wb_addr_in;
          req_reg_write_d = reg_write_in;
          req_we_d        = store_in;
          req_be_d        = store_in ? store_be : BE_NONE;
          req_wdata_d     = store_in ? store_wdata : '0;
          wb_valid_d      = 1'b0;
          exc_d           = 1'b0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        stall_out = !bus.mem_ready;
        if (bus.mem_ready) begin
          wb_valid_d = 1'b1;
          exc_d      = 1'b0;
          wb_addr_d  = req_rd_q;
          state_d    = IDLE;
          if (req_we_q) begin
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = load_data;
            wb_reg_write_d = req_reg_write_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset withdraws any in-flight request immediately by returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      req_addr_q      <= '0;
      req_funct3_q    <= '0;
      req_rd_q        <= '0;
      req_reg_write_q <= 1'b0;
      req_be_q        <= '0;
      req_wdata_q     <= '0;
      req_we_q        <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_data_q       <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_addr_q       <= '0;
      exc_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_addr_q      <= req_addr_d;
      req_funct3_q    <= req_funct3_d;
      req_rd_q        <= req_rd_d;
      req_reg_write_q <= req_reg_write_d;
      req_be_q        <= req_be_d;
      req_wdata_q     <= req_wdata_d;
      req_we_q        <= req_we_d;
      wb_valid_q      <= wb_valid_d;
      wb_data_q       <= wb_data_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_addr_q       <= wb_addr_d;
      exc_q           <= exc_d;
    end
  end

  assign bus.mem_req   = (state_q == BUSY);
  assign bus.mem_we    = req_we_q;
  assign bus.mem_addr  = word_align(req_addr_q);
  assign bus.mem_wdata = req_wdata_q;
  assign bus.mem_be    = req_be_q;

  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_addr      = wb_addr_q;
  assign exc_out      = exc_q;

endmodule
